// File: rtl/serial_wide_sub.sv
// serial_wide_sub
// ---------------------------------------------------------------------------
// Word-serial wide subtractor. Computes D = A - B for an operand pair of
// N_WORDS x WORD_W bits, streamed least-significant word first. The borrow
// between words is kept in a register, so one word is processed per cycle.
// The result streams out through a single registered output stage. The final
// borrow (A < B) is flagged on the last result word.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : asynchronous active-high reset
//   clr        : synchronous abort (drops the in-flight operand and clears state)
//   in_valid   : a_word / b_word / in_last are valid
//   in_ready   : the block can accept a word this cycle
//   a_word     : minuend word, LS word first
//   b_word     : subtrahend word, LS word first
//   in_last    : producer's end-of-operand marker (checked, never obeyed)
//   out_valid  : diff_word is valid
//   out_ready  : the consumer accepts diff_word
//   diff_word  : result word
//   out_last   : diff_word is word N_WORDS-1
//   borrow_out : final borrow (1 = A < B); valid with out_last, else 0
//   len_err    : in_last disagreed with the internal word index for this word
//   busy       : an operand is in progress (word index != 0)
// ---------------------------------------------------------------------------
module serial_wide_sub #(
    parameter int WORD_W  = 64,
    parameter int N_WORDS = 64,
    parameter int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] a_word,
    input  logic [WORD_W-1:0] b_word,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] diff_word,
    output logic              out_last,
    output logic              borrow_out,
    output logic              len_err,
    output logic              busy
);

    // The word index is the state. Index 0 is IDLE and any other value is RUN.
    localparam logic [CNT_W-1:0] IDX_IDLE = '0;
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(N_WORDS - 1);

    logic [CNT_W-1:0]  r_idx;
    logic              r_borrow;
    logic              r_out_valid;
    logic [WORD_W-1:0] r_diff;
    logic              r_out_last;
    logic              r_borrow_out;
    logic              r_len_err;

    logic              w_accept;
    logic              w_at_last;
    logic              w_borrow_in;
    logic [WORD_W:0]   w_t;

    // The output stage is one entry deep. It can take a new word whenever it
    // is empty or is being drained in this same cycle.
    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_at_last = (r_idx == IDX_LAST);

    // Word 0 always starts with no borrow. This way a stale borrow can never
    // leak from one operand into the next, even after an abort.
    assign w_borrow_in = (r_idx == IDX_IDLE) ? 1'b0 : r_borrow;

    // Subtract one bit wider than a word. The top bit is the borrow out of this word.
    assign w_t = {1'b0, a_word} - {1'b0, b_word} - {{WORD_W{1'b0}}, w_borrow_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= IDX_IDLE;
            r_borrow     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_diff       <= '0;
            r_out_last   <= 1'b0;
            r_borrow_out <= 1'b0;
            r_len_err    <= 1'b0;
        end else if (clr) begin
            // Abort takes priority over accept. The presented word is dropped.
            r_idx        <= IDX_IDLE;
            r_borrow     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_diff       <= '0;
            r_out_last   <= 1'b0;
            r_borrow_out <= 1'b0;
            r_len_err    <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_diff       <= w_t[WORD_W-1:0];
            r_out_last   <= w_at_last;
            r_borrow_out <= w_at_last ? w_t[WORD_W] : 1'b0;
            // in_last is only reported. The sequencing follows the index alone.
            r_len_err    <= (in_last != w_at_last);
            if (w_at_last) begin
                r_idx    <= IDX_IDLE;
                r_borrow <= 1'b0;
            end else begin
                r_idx    <= r_idx + 1'b1;
                r_borrow <= w_t[WORD_W];
            end
        end else if (r_out_valid && out_ready) begin
            // The word drained with nothing new behind it. The data fields keep their values.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign diff_word  = r_diff;
    assign out_last   = r_out_last;
    assign borrow_out = r_borrow_out;
    assign len_err    = r_len_err;
    assign busy       = (r_idx != IDX_IDLE);

endmodule

// File: doc/serial_wide_sub.md
Name: serial_wide_sub

Overview:
- Word-serial wide subtractor: computes D = A − B for an N_WORDS×WORD_W-bit operand pair (default 4096 bits), least-significant word first.
- Ripples a registered borrow between words.
- Serves as the final conditional-subtraction / modulus-reduction stage next to the IDDMM multiplier datapath, counterpart to the existing adder chain.
- Streams in on a valid/ready input and streams out on a registered valid/ready output, flagging the final borrow (A < B).

Parameters:
WORD_W, 64, width of one operand/result word in bits
N_WORDS, 64, words per operand (operand width = WORD_W*N_WORDS)
CNT_W, $clog2(N_WORDS), width of word index counter (derived, min 1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
clr  in  1  synchronous abort: drop in-flight operand, clear counter/borrow/output
in_valid  in  1  a_word/b_word/in_last valid
in_ready  out  1  block can accept a word this cycle
a_word  in  WORD_W  minuend word, LS word first
b_word  in  WORD_W  subtrahend word, LS word first
in_last  in  1  producer's marker for final word of operand
out_valid  out  1  diff_word valid
out_ready  in  1  consumer accepts diff_word
diff_word  out  WORD_W  result word
out_last  out  1  diff_word is word N_WORDS-1
borrow_out  out  1  final borrow (1 = A < B); meaningful only when out_last=1, else 0
len_err  out  1  in_last disagreed with internal word index for this word
busy  out  1  operand in progress (word index != 0)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. Reset and clr values: out_valid=0, diff_word=0, out_last=0, borrow_out=0, len_err=0, busy=0, word index=0, borrow register=0.
- Handshake:
  - in_ready = !out_valid || out_ready (1-deep output register, combinational ready).
  - Accept = in_valid && in_ready. Output transfer = out_valid && out_ready.
  - out_valid, diff_word, out_last, borrow_out and len_err are held stable while out_valid && !out_ready.
- Arithmetic per accepted word:
  - t = {1'b0,a_word} − {1'b0,b_word} − borrow_reg, computed (WORD_W+1) bits wide.
  - diff_word ← t[WORD_W-1:0]; borrow_reg ← t[WORD_W].
  - Word index 0 always uses borrow 0, so no borrow leaks between operands.
- Latency: 1 cycle. Word accepted at edge k appears on diff_word with out_valid=1 after edge k. Full throughput of 1 word/cycle when out_ready is held high.
- Index FSM (states encoded by word index):
  - IDLE (idx=0, busy=0) → RUN on accept.
  - RUN (idx 1..N_WORDS-1, busy=1) increments on each accept.
  - Accepting idx N_WORDS-1 sets out_last=1 and borrow_out=t[WORD_W], wraps idx to 0 and clears borrow_reg in the same edge.
  - If N_WORDS=1, every word is last.
- len_err: registered with each output word. Set to (in_last != (idx==N_WORDS-1)). Information only: sequencing follows the internal index, never in_last.
- Output without new input: when out_valid && out_ready && !accept, out_valid ← 0 next edge. The other output fields may hold their values. A simultaneous transfer plus accept loads the new word with no bubble.
- clr: sampled on the rising edge and has priority over accept. The word presented in the clr cycle is dropped. clr while idle is harmless.
- Reset mid-operation: the partial result is discarded and no words are emitted. The next accepted word is treated as word 0.

Test Plan (bench uses WORD_W=4, N_WORDS=4, operands shown as 16-bit hex):
- Basic equal: A=0x1234, B=0x1234, out_ready=1 → diff words 0,0,0,0; out_last on 4th only; borrow_out=0; len_err=0; one word per cycle, 1-cycle latency.
- Full borrow ripple: A=0x0000, B=0x0001 → diff words F,F,F,F; borrow_out=1 with 4th word. Then immediately A=0x0005, B=0x0003 → 2,0,0,0 with borrow_out=0 (no borrow carried across operands).
- Backpressure: A=0xA5A5, B=0x5A5A, out_ready low for 3 cycles after word 1 output → diff_word=B held stable, in_ready=0, no word lost. Final result 0x4B4B, borrow_out=0.
- Length check: in_last asserted on word index 1 and deasserted on index 3 → len_err=1 on output words 1 and 3, 0 on others. Result still correct over 4 words.
- Abort: assert clr (then, separately, rst) after 2 words of A=0xFFFF, B=0x0001 → out_valid=0 next cycle, busy=0. Then send A=0x0010, B=0x0001 → 0xF,0,0,0, borrow_out=0.
- Random: 10k random operand pairs against a 16-bit golden model with random out_ready/in_valid gaps → every {borrow_out, D} matches A − B mod 2^16 with borrow = (A<B).
